// File: rtl/vid_pkg.sv
// Shared video pipeline constants: pixel width, line address width, transparent value.
package vid_pkg;

  localparam int PIX_W   = 8;
  localparam int LINE_AW = 8;
  localparam logic [PIX_W-1:0] PIX_TRANSP = '0;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

endpackage

// File: rtl/lb_bank_ram.sv
// One line-buffer bank: simple dual-port RAM, synchronous write and registered read.
module lb_bank_ram
  import vid_pkg::*;
#(
  parameter int DW = PIX_W,
  parameter int AW = LINE_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-edge write to raddr is not visible here: read-before-write.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_buffer_pp.sv
// Ping-pong line buffer: render writes one bank while scanout reads (and optionally clears) the other.
module line_buffer_pp
  import vid_pkg::*;
#(
  parameter int            DW        = PIX_W,
  parameter int            AW        = LINE_AW,
  parameter int            TRANSP_EN = 1,
  parameter logic [DW-1:0] TRANSP    = DW'(PIX_TRANSP),
  parameter int            CLR_EN    = 1,
  parameter logic [DW-1:0] CLR_VAL   = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          swap,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          wbank
);

  bank_e         wr_bank_q;
  bank_e         rd_sel_q;
  logic          wr_ok;
  logic          clr_ok;
  logic [DW-1:0] bank_rdata [2];

  assign wr_ok  = wr_en && !((TRANSP_EN != 0) && (wr_data == TRANSP));
  assign clr_ok = rd_en && (CLR_EN != 0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q <= BANK_0;
      rd_sel_q  <= BANK_0;
      rd_valid  <= 1'b0;
    end else begin
      if (swap) wr_bank_q <= other_bank(wr_bank_q);
      if (rd_en) rd_sel_q <= other_bank(wr_bank_q);
      rd_valid <= rd_en;
    end
  end

  // Each bank's write port is owned by the renderer or by clear-on-read, never both.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam bank_e ME = (b == 0) ? BANK_0 : BANK_1;
    logic          is_wr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re;
    logic [DW-1:0] rdata;

    assign is_wr = (wr_bank_q == ME);
    assign we    = !reset && (is_wr ? wr_ok : clr_ok);
    assign waddr = is_wr ? wr_addr : rd_addr;
    assign wdata = is_wr ? wr_data : CLR_VAL;
    assign re    = rd_en && !is_wr;

    lb_bank_ram #(
      .DW(DW),
      .AW(AW)
    ) u_ram (
      .clk  (clk),
      .reset(reset),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .re   (re),
      .raddr(rd_addr),
      .rdata(rdata)
    );

    assign bank_rdata[b] = rdata;
  end

  // Bank outputs only update on their own reads, so holding the select holds rd_data.
  assign rd_data = (rd_sel_q == BANK_1) ? bank_rdata[1] : bank_rdata[0];
  assign wbank   = (wr_bank_q == BANK_1);

endmodule

// File: tb/tb_line_buffer_pp.sv
// Bench for line_buffer_pp: clear-on-read instance and a CLR_EN=0 instance checked against a bank/array model.
module tb_line_buffer_pp;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       swap = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_addr = '0;

  logic [7:0] rd_data_a, rd_data_b;
  logic       rd_valid_a, rd_valid_b;
  logic       wbank_a, wbank_b;

  logic [7:0] act_data  [2];
  logic       act_valid [2];
  logic       act_wbank [2];

  // model: instance 0 clears on read, instance 1 does not
  logic [7:0] mdl_mem   [2][2][256];
  bit         mdl_known [2][2][256];
  logic [7:0] exp_data  [2];
  bit         exp_known [2];
  logic       exp_valid [2];
  logic       exp_wbank [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_buffer_pp dut_a (
    .clk(clk), .reset(reset), .swap(swap),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .wbank(wbank_a)
  );

  line_buffer_pp #(.CLR_EN(0)) dut_b (
    .clk(clk), .reset(reset), .swap(swap),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wbank(wbank_b)
  );

  assign act_data[0]  = rd_data_a;
  assign act_data[1]  = rd_data_b;
  assign act_valid[0] = rd_valid_a;
  assign act_valid[1] = rd_valid_b;
  assign act_wbank[0] = wbank_a;
  assign act_wbank[1] = wbank_b;

  task automatic tick();
    bit rb;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        exp_wbank[i] = 1'b0;
        exp_valid[i] = 1'b0;
        exp_data[i]  = 8'h00;
        exp_known[i] = 1'b1;
      end else begin
        rb = !exp_wbank[i];
        if (rd_en) begin
          exp_data[i]  = mdl_mem[i][rb][rd_addr];
          exp_known[i] = mdl_known[i][rb][rd_addr];
          exp_valid[i] = 1'b1;
          if (i == 0) begin
            mdl_mem[i][rb][rd_addr]   = 8'h00;
            mdl_known[i][rb][rd_addr] = 1'b1;
          end
        end else begin
          exp_valid[i] = 1'b0;
        end
        if (wr_en && wr_data != 8'h00) begin
          mdl_mem[i][exp_wbank[i]][wr_addr]   = wr_data;
          mdl_known[i][exp_wbank[i]][wr_addr] = 1'b1;
        end
        if (swap) exp_wbank[i] = !exp_wbank[i];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    swap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_en = 1'b1; rd_addr = 8'h10;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_valid[i] !== 1'b0 || act_data[i] !== 8'h00 || act_wbank[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] got valid=%b data=%h wbank=%b want valid=0 data=00 wbank=0",
                 i, act_valid[i], act_data[i], act_wbank[i]);
      end
    end
    reset = 1'b0; idle();
    tick();
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_addr = 8'h10; wr_data = 8'h5A; tick();
    idle(); swap = 1'b1; tick();
    idle(); rd_en = 1'b1; rd_addr = 8'h10; tick();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h5A || wbank_a !== 1'b1) begin
      errors++;
      $display("FAIL basic_read1 got valid=%b data=%h wbank=%b want valid=1 data=5a wbank=1",
               rd_valid_a, rd_data_a, wbank_a);
    end
    tick();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin
      errors++;
      $display("FAIL basic_read2_cleared got valid=%b data=%h want valid=1 data=00", rd_valid_a, rd_data_a);
    end
    checks++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 8'h5A) begin
      errors++;
      $display("FAIL noclr_read2 got valid=%b data=%h want valid=1 data=5a", rd_valid_b, rd_data_b);
    end
    idle(); tick();
    checks++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 8'h00) begin
      errors++;
      $display("FAIL basic_hold got valid=%b data=%h want valid=0 data=00", rd_valid_a, rd_data_a);
    end
  endtask

  task automatic test_transp();
    wr_en = 1'b1; wr_addr = 8'h20; wr_data = 8'h33; tick();
    wr_data = 8'h00; tick();
    idle(); swap = 1'b1; tick();
    idle(); rd_en = 1'b1; rd_addr = 8'h20; tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_valid[i] !== 1'b1 || act_data[i] !== 8'h33) begin
        errors++;
        $display("FAIL transp[%0d] got valid=%b data=%h want valid=1 data=33", i, act_valid[i], act_data[i]);
      end
    end
    idle(); tick();
  endtask

  task automatic test_swap_read();
    wr_en = 1'b1; wr_addr = 8'h30; wr_data = 8'hA1; tick();
    idle(); swap = 1'b1; tick();
    idle(); wr_en = 1'b1; wr_addr = 8'h30; wr_data = 8'hB2; tick();
    idle(); swap = 1'b1; rd_en = 1'b1; rd_addr = 8'h30; tick();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'hA1 || wbank_a !== 1'b0) begin
      errors++;
      $display("FAIL swap_read_old got valid=%b data=%h wbank=%b want valid=1 data=a1 wbank=0",
               rd_valid_a, rd_data_a, wbank_a);
    end
    swap = 1'b0; tick();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'hB2) begin
      errors++;
      $display("FAIL swap_read_new got valid=%b data=%h want valid=1 data=b2", rd_valid_a, rd_data_a);
    end
    idle(); tick();
  endtask

  task automatic test_concurrent();
    rd_en = 1'b1; rd_addr = 8'h40; tick();
    idle(); wr_en = 1'b1; wr_addr = 8'h40; wr_data = 8'h77; rd_en = 1'b1; rd_addr = 8'h40; tick();
    checks++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'h00) begin
      errors++;
      $display("FAIL concurrent_read got valid=%b data=%h want valid=1 data=00", rd_valid_a, rd_data_a);
    end
    idle(); swap = 1'b1; tick();
    idle(); rd_en = 1'b1; rd_addr = 8'h40; tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_valid[i] !== 1'b1 || act_data[i] !== 8'h77) begin
        errors++;
        $display("FAIL concurrent_after_swap[%0d] got valid=%b data=%h want valid=1 data=77",
                 i, act_valid[i], act_data[i]);
      end
    end
    idle(); tick();
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 256; a++) begin
      idle(); wr_en = 1'b1; wr_addr = 8'(a); wr_data = 8'($urandom_range(1, 255)); tick();
    end
    idle(); swap = 1'b1; tick();
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < 256; a++) begin
        idle();
        wr_en = (pass == 0); wr_addr = 8'(a); wr_data = 8'($urandom_range(1, 255));
        rd_en = 1'b1; rd_addr = 8'(a);
        tick();
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (act_valid[i] !== 1'b1 || (exp_known[i] && act_data[i] !== exp_data[i])) begin
            errors++;
            $display("FAIL sweep[%0d] pass=%0d addr=%h got valid=%b data=%h want valid=1 data=%h",
                     i, pass, a, act_valid[i], act_data[i], exp_data[i]);
          end
        end
      end
      idle(); swap = 1'b1; tick();
    end
    idle(); tick();
  endtask

  task automatic test_random_traffic();
    for (int n = 0; n < 600; n++) begin
      swap    = ($urandom_range(0, 15) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 8'($urandom_range(0, 7));
      wr_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      rd_en   = ($urandom_range(0, 3) != 0);
      rd_addr = 8'($urandom_range(0, 7));
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_valid[i] !== exp_valid[i] || act_wbank[i] !== exp_wbank[i] ||
            (exp_known[i] && act_data[i] !== exp_data[i])) begin
          errors++;
          $display("FAIL random[%0d] cyc=%0d got valid=%b wbank=%b data=%h want valid=%b wbank=%b data=%h",
                   i, n, act_valid[i], act_wbank[i], act_data[i], exp_valid[i], exp_wbank[i], exp_data[i]);
        end
      end
    end
    idle(); tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      exp_data[i] = 8'h00; exp_known[i] = 1'b0; exp_valid[i] = 1'b0; exp_wbank[i] = 1'b0;
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 256; a++) begin
          mdl_mem[i][b][a]   = 8'h00;
          mdl_known[i][b][a] = 1'b0;
        end
    end
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_transp();
    test_swap_read();
    test_concurrent();
    test_sweep();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
